mo_line_writer: RTL and testbench
=================================

# mo_line_writer

Double-buffered motion-object line buffer for the video path. The block owns two 256×8 line RAMs, each with one address port, a registered read (one-cycle latency) and a write; it runs them ping-pong. During each scanline it writes motion-object pixel rows into the write bank while scanning out the display bank to the video mixer, clearing each display location as it is read. Banks swap on every line-start pulse.

## Interface
- No parameters; line length fixed at 256 pixels, object row width fixed at 16 pixels.
- clk  in  1  system clock; drives both RAMs' read and write clocks.
- reset  in  1  synchronous, active-high.
- line_start  in  1  one-cycle pulse at start of each scanline; swaps banks.
- pix_en  in  1  pixel-clock enable; one display pixel is read per asserted cycle.
- mo_valid  in  1  object row offered.
- mo_ready  out  1  block can accept a row; defined as (state==IDLE) & ~line_start.
- mo_x  in  8  screen X of the row's pixel 0.
- mo_row  in  32  16 pixels × 2 bits; pixel k = mo_row[2k+1:2k]; code 0 is transparent.
- mo_pal  in  6  palette for the row.
- pix_out  out  8  display pixel {pal[5:0], code[1:0]}; 0 when pix_valid is low.
- pix_valid  out  1  pix_out carries a scanned pixel.
- mo_overrun  out  1  one-cycle pulse: a row write was aborted by line_start.
- wbank  out  1  current write bank; display bank is ~wbank.

## Operation
- States: INIT, IDLE, WRITE.
- INIT: entered on reset. addr counter 0..255, writes 0 to both banks each cycle (256 cycles), then IDLE. During INIT: mo_ready=0, pix_valid=0, line_start and pix_en ignored (no bank toggle).
- IDLE: mo_ready high unless line_start. Accept on mo_valid & mo_ready: latch mo_x, mo_row, mo_pal, idx=0, go to WRITE.
- WRITE: one pixel per cycle, idx 0..15. Address = mo_x + idx as a 9-bit sum. Write {pal, code} to write bank only if code≠0 and sum<256; transparent or off-screen (sum≥256) pixels are skipped, with no wrap. After idx=15, go to IDLE.
- Later writes overwrite earlier ones at the same address (last object wins).
- Abort: line_start while in WRITE.
  - The write issued on the line_start cycle completes into the old bank.
  - Next cycle: IDLE, mo_overrun=1 for one cycle, remaining pixels dropped.
- Scan (display bank, independent of writer state outside INIT):
  - On pix_en with scan_done=0: read at scan_addr and, in the same cycle, write 0 at scan_addr. Read returns the pre-clear data.
  - scan_addr increments; scan_done set after address 255.
  - pix_en with scan_done=1 is ignored.
- line_start (outside INIT): wbank toggles, scan_addr←0, scan_done←0. pix_en on the line_start cycle is ignored.
- Reset values: state=INIT, wbank=0, scan_addr=0, scan_done=0, mo_ready=0, pix_valid=0, pix_out=0, mo_overrun=0. Reset mid-line or mid-write discards everything and re-runs INIT.

## Timing
- INIT lasts exactly 256 cycles after reset deasserts; mo_ready rises on cycle 257.
- Row accepted at cycle t: pixel k written at edge ending cycle t+1+k; mo_ready high again at t+17. Throughput: 17 cycles per row.
- Scan latency: pix_en at cycle t → pix_valid=1 and pix_out valid at t+1.
- A row written during line N is displayed during line N+1; after display it reads 0 on line N+3.

## Test plan
- Reset, then count cycles → mo_ready=0 for 256 cycles, then 1. Scan a full line → all 256 pix_out=0.
- Row mo_x=10, mo_row=0x0000_0003 (pixel 0 code 3), mo_pal=0x15, then line_start, then 256 pix_en → pix_out=0x57 only at X=10, 0 elsewhere. Next scan of the same bank → all 0 (cleared).
- mo_x=250, mo_row=0xFFFF_FFFF → after swap, X=250..255 hold {pal,3}; X=0..9 are 0 (no wrap).
- Transparency/overlap: row A at X=20 all code 1, then row B at X=20 with alternate codes 0/2 (mo_row=0x8888_8888) → even X = code 1, odd X = code 2.
- line_start 5 cycles into WRITE → mo_overrun pulses once; only pixels 0..4 appear next line; mo_ready high the cycle after.
- mo_valid held high with line_start on the same cycle → no accept that cycle (mo_ready=0); accept on the next cycle goes into the new wbank.

Source files
------------

// File: rtl/mo_line_writer_if.sv
// Motion-object row handshake: the sprite engine offers one 16-pixel row
// at a time and the line writer accepts it when ready.
interface mo_line_writer_if;
    logic        mo_valid;
    logic        mo_ready;
    logic [7:0]  mo_x;
    logic [31:0] mo_row;
    logic [5:0]  mo_pal;

    modport master (
        output mo_valid,
        output mo_x,
        output mo_row,
        output mo_pal,
        input  mo_ready
    );

    modport slave (
        input  mo_valid,
        input  mo_x,
        input  mo_row,
        input  mo_pal,
        output mo_ready
    );
endinterface

// File: rtl/mo_line_writer.sv
// Ping-pong motion-object line buffer: rows are painted into the write bank
// while the display bank is scanned out and cleared behind the read.
module mo_line_writer (
    input  logic                  clk,
    input  logic                  reset,
    mo_line_writer_if.slave       mo,
    input  logic                  line_start,
    input  logic                  pix_en,
    output logic [7:0]            pix_out,
    output logic                  pix_valid,
    output logic                  mo_overrun,
    output logic                  wbank
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE
    } state_t;

    state_t      state_q;
    logic [7:0]  init_addr_q;
    logic [3:0]  idx_q;
    logic [7:0]  x_q;
    logic [31:0] row_q;
    logic [5:0]  pal_q;
    logic        wbank_q;
    logic [7:0]  scan_addr_q;
    logic        scan_done_q;
    logic        pix_valid_q;
    logic        rd_bank_q;
    logic        overrun_q;

    logic        in_init;
    logic [8:0]  wr_sum;
    logic [1:0]  wr_code;
    logic        wr_fire;
    logic        scan_fire;
    logic        accept;

    assign in_init   = (state_q == ST_INIT);
    // 9-bit sum so pixels past the right edge are dropped instead of wrapping
    assign wr_sum    = {1'b0, x_q} + {5'd0, idx_q};
    assign wr_code   = row_q[{idx_q, 1'b0} +: 2];
    assign wr_fire   = (state_q == ST_WRITE) && (wr_code != 2'd0) && !wr_sum[8];
    assign scan_fire = !in_init && pix_en && !scan_done_q && !line_start;
    assign mo.mo_ready = (state_q == ST_IDLE) && !line_start;
    assign accept    = mo.mo_valid && mo.mo_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] mem [0:255];
            logic [7:0] rdata_q;
            logic       we;
            logic [7:0] addr;
            logic [7:0] wdata;

            // One address port per bank: INIT clears both, otherwise the
            // write bank serves the writer and the other bank the scanner.
            always_comb begin
                we    = 1'b0;
                addr  = 8'd0;
                wdata = 8'd0;
                if (in_init) begin
                    we   = 1'b1;
                    addr = init_addr_q;
                end else if (wbank_q == 1'(gi)) begin
                    we    = wr_fire;
                    addr  = wr_sum[7:0];
                    wdata = {pal_q, wr_code};
                end else begin
                    we   = scan_fire;
                    addr = scan_addr_q;
                end
            end

            always_ff @(posedge clk) begin
                rdata_q <= mem[addr];
                if (we) begin
                    mem[addr] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= 8'd0;
            idx_q       <= 4'd0;
            x_q         <= 8'd0;
            row_q       <= 32'd0;
            pal_q       <= 6'd0;
            wbank_q     <= 1'b0;
            scan_addr_q <= 8'd0;
            scan_done_q <= 1'b0;
            pix_valid_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pix_valid_q <= scan_fire;
            overrun_q   <= 1'b0;

            if (scan_fire) begin
                rd_bank_q   <= ~wbank_q;
                scan_addr_q <= scan_addr_q + 8'd1;
                if (scan_addr_q == 8'd255) begin
                    scan_done_q <= 1'b1;
                end
            end

            if (!in_init && line_start) begin
                wbank_q     <= ~wbank_q;
                scan_addr_q <= 8'd0;
                scan_done_q <= 1'b0;
            end

            case (state_q)
                ST_INIT: begin
                    init_addr_q <= init_addr_q + 8'd1;
                    if (init_addr_q == 8'd255) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        x_q     <= mo.mo_x;
                        row_q   <= mo.mo_row;
                        pal_q   <= mo.mo_pal;
                        idx_q   <= 4'd0;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The pixel issued this cycle still lands in the old bank.
                    if (line_start) begin
                        state_q   <= ST_IDLE;
                        overrun_q <= 1'b1;
                    end else if (idx_q == 4'd15) begin
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_out    = !pix_valid_q ? 8'd0 :
                        (rd_bank_q ? g_bank[1].rdata_q : g_bank[0].rdata_q);
    assign mo_overrun = overrun_q;
    assign wbank      = wbank_q;

endmodule

// File: tb/tb_mo_line_writer.sv
// Bench for mo_line_writer: a line-level model (two pixel arrays plus scan
// position) predicts every scanned pixel, overrun pulse and bank select.
module tb_mo_line_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic       pix_en;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       mo_overrun;
    logic       wbank;

    mo_line_writer_if mo_if ();

    mo_line_writer dut (
        .clk        (clk),
        .reset      (reset),
        .mo         (mo_if.slave),
        .line_start (line_start),
        .pix_en     (pix_en),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .mo_overrun (mo_overrun),
        .wbank      (wbank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [31:0] row;
        logic [5:0]  pal;
        bit          two;
        logic [7:0]  x2;
        logic [31:0] row2;
        logic [5:0]  pal2;
        int          probe;
        logic [7:0]  exp;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] mbank [2][256];
    logic [7:0] cap [256];
    bit         mwb;
    int         saddr;
    bit         sdone;
    bit         in_init;
    int         init_left;
    bit         writing;
    int         pe_mode;
    vec_t       vecs [9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock, updating the model with what this cycle's inputs mean.
    task automatic next();
        bit         ev = 1'b0;
        logic [7:0] ep = 8'd0;
        bit         eo;
        bit         init_cyc = 1'b0;
        int         cur = 0;
        case (pe_mode)
            1:       pix_en = 1'b1;
            2:       pix_en = 1'($urandom_range(0, 1));
            default: pix_en = 1'b0;
        endcase
        eo = line_start && writing && !in_init && !reset;
        if (reset) begin
            in_init = 1'b1;
            init_left = 256;
            mwb = 1'b0;
            saddr = 0;
            sdone = 1'b0;
            for (int a = 0; a < 256; a++) begin
                mbank[0][a] = 8'd0;
                mbank[1][a] = 8'd0;
            end
        end else if (in_init) begin
            init_cyc = 1'b1;
            init_left--;
        end else if (line_start) begin
            mwb = ~mwb;
            saddr = 0;
            sdone = 1'b0;
        end else if (pix_en && !sdone) begin
            ev = 1'b1;
            cur = saddr;
            ep = mbank[!mwb][saddr];
            mbank[!mwb][saddr] = 8'd0;
            saddr++;
            if (saddr == 256) sdone = 1'b1;
        end
        @(posedge clk);
        #1;
        if (init_cyc && init_left == 0) in_init = 1'b0;
        check("pix_valid", int'(pix_valid), int'(ev));
        check("pix_out", int'(pix_out), int'(ep));
        check("mo_overrun", int'(mo_overrun), int'(eo));
        check("wbank", int'(wbank), int'(mwb));
        if (ev) cap[cur] = pix_out;
    endtask

    task automatic apply_row(input logic [7:0] x, input logic [31:0] row,
                             input logic [5:0] pal, input int n);
        for (int k = 0; k < n; k++) begin
            int         a = int'(x) + k;
            logic [1:0] c = 2'((row >> (2 * k)) & 32'd3);
            if (a < 256 && c != 2'd0) mbank[mwb][a] = {pal, c};
        end
    endtask

    task automatic send_row(input logic [7:0] x, input logic [31:0] row,
                            input logic [5:0] pal, input int abort_at, input bit with_ls);
        mo_if.mo_x = x;
        mo_if.mo_row = row;
        mo_if.mo_pal = pal;
        mo_if.mo_valid = 1'b1;
        if (with_ls) begin
            line_start = 1'b1;
            #1 check("ready_on_line_start", int'(mo_if.mo_ready), 0);
            next();
            line_start = 1'b0;
        end
        #1 check("ready_accept", int'(mo_if.mo_ready), 1);
        next();
        mo_if.mo_valid = 1'b0;
        writing = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                #1 check("ready_busy", int'(mo_if.mo_ready), 0);
            end
            if (k == abort_at) begin
                apply_row(x, row, pal, k + 1);
                line_start = 1'b1;
                next();
                line_start = 1'b0;
                writing = 1'b0;
                #1 check("ready_after_abort", int'(mo_if.mo_ready), 1);
                return;
            end
            next();
        end
        writing = 1'b0;
        apply_row(x, row, pal, 16);
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        #1 check("ready_line_start", int'(mo_if.mo_ready), 0);
        next();
        line_start = 1'b0;
    endtask

    task automatic scan_line();
        for (int a = 0; a < 256; a++) cap[a] = 8'hEE;
        pe_mode = 1;
        repeat (256) next();
        pe_mode = 0;
    endtask

    function automatic int count_nonzero();
        int n = 0;
        for (int a = 0; a < 256; a++) if (cap[a] != 8'd0) n++;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int zeros;
        bit aborted;
        vecs[0] = '{8'd10,  32'h0000_0003, 6'h15, 1'b0, 8'd0,  32'd0,         6'd0,   10, 8'h57};
        vecs[1] = '{8'd10,  32'h0000_0003, 6'h15, 1'b0, 8'd0,  32'd0,         6'd0,   11, 8'h00};
        vecs[2] = '{8'd250, 32'hFFFF_FFFF, 6'h2A, 1'b0, 8'd0,  32'd0,         6'd0,  255, 8'hAB};
        vecs[3] = '{8'd250, 32'hFFFF_FFFF, 6'h2A, 1'b0, 8'd0,  32'd0,         6'd0,    0, 8'h00};
        vecs[4] = '{8'd20,  32'h5555_5555, 6'h01, 1'b1, 8'd20, 32'h8888_8888, 6'h02,  20, 8'h05};
        vecs[5] = '{8'd20,  32'h5555_5555, 6'h01, 1'b1, 8'd20, 32'h8888_8888, 6'h02,  21, 8'h0A};
        vecs[6] = '{8'd240, 32'hC000_0000, 6'h3F, 1'b0, 8'd0,  32'd0,         6'd0,  255, 8'hFF};
        vecs[7] = '{8'd255, 32'h0000_000E, 6'h01, 1'b0, 8'd0,  32'd0,         6'd0,  255, 8'h06};
        vecs[8] = '{8'd255, 32'h0000_000E, 6'h01, 1'b0, 8'd0,  32'd0,         6'd0,    0, 8'h00};

        reset = 1'b1;
        line_start = 1'b0;
        pix_en = 1'b0;
        mo_if.mo_valid = 1'b0;
        mo_if.mo_x = 8'd0;
        mo_if.mo_row = 32'd0;
        mo_if.mo_pal = 6'd0;
        pe_mode = 0;
        writing = 1'b0;
        in_init = 1'b1;
        init_left = 256;
        mwb = 1'b0;
        saddr = 0;
        sdone = 1'b0;

        repeat (3) next();
        check("ready_in_reset", int'(mo_if.mo_ready), 0);
        reset = 1'b0;

        // INIT length, with scan and line_start poked to show they are ignored.
        zeros = 0;
        pe_mode = 1;
        for (int i = 0; i < 256; i++) begin
            line_start = (i == 100);
            #1 if (!mo_if.mo_ready) zeros++;
            next();
        end
        line_start = 1'b0;
        pe_mode = 0;
        check("init_len", zeros, 256);
        #1 check("ready_after_init", int'(mo_if.mo_ready), 1);

        scan_line();
        check("blank_line", count_nonzero(), 0);

        for (int i = 0; i < 9; i++) begin
            pulse_line();
            send_row(vecs[i].x, vecs[i].row, vecs[i].pal, -1, 1'b0);
            if (vecs[i].two) send_row(vecs[i].x2, vecs[i].row2, vecs[i].pal2, -1, 1'b0);
            pulse_line();
            scan_line();
            check($sformatf("vec%0d_x%0d", i, vecs[i].probe), int'(cap[vecs[i].probe]), int'(vecs[i].exp));
        end

        // Displayed bank must read back as zero two swaps later.
        pulse_line();
        scan_line();
        pulse_line();
        scan_line();
        check("cleared_after_display", count_nonzero(), 0);

        pulse_line();
        send_row(8'd100, 32'hFFFF_FFFF, 6'h07, 4, 1'b0);
        scan_line();
        check("abort_x100", int'(cap[100]), 8'h1F);
        check("abort_x104", int'(cap[104]), 8'h1F);
        check("abort_x105", int'(cap[105]), 8'h00);

        send_row(8'd50, 32'h0000_0001, 6'h09, -1, 1'b1);
        pulse_line();
        scan_line();
        check("ls_with_valid_x50", int'(cap[50]), 8'h25);

        pe_mode = 2;
        for (int ln = 0; ln < 30; ln++) begin
            aborted = 1'b0;
            for (int r = 0; r < int'($urandom_range(0, 3)) && !aborted; r++) begin
                int ab;
                repeat ($urandom_range(0, 3)) next();
                ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : -1;
                send_row(8'($urandom), $urandom, 6'($urandom_range(0, 63)), ab,
                         $urandom_range(0, 3) == 0);
                if (ab >= 0) aborted = 1'b1;
            end
            repeat ($urandom_range(0, 40)) next();
            if (!aborted) pulse_line();
        end
        pe_mode = 0;

        // Reset in the middle of a row write wipes both banks.
        pulse_line();
        send_row(8'd30, 32'hFFFF_FFFF, 6'h11, -1, 1'b0);
        mo_if.mo_x = 8'd60;
        mo_if.mo_row = 32'hFFFF_FFFF;
        mo_if.mo_pal = 6'h22;
        mo_if.mo_valid = 1'b1;
        next();
        mo_if.mo_valid = 1'b0;
        writing = 1'b1;
        repeat (3) next();
        writing = 1'b0;
        reset = 1'b1;
        repeat (2) next();
        reset = 1'b0;
        repeat (256) next();
        scan_line();
        check("reset_clear_bank1", count_nonzero(), 0);
        pulse_line();
        scan_line();
        check("reset_clear_bank0", count_nonzero(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
